regfile_sb_multi: RTL and testbench
===================================

Name: regfile_sb_multi

Overview:
- Parametrised register file; successor to the fixed 32x32, 2-read-port FP register file.
- Generalises width, depth and read-port count; zero-register hardwiring is optional, for integer or FP use.
- Adds write-to-read bypass, a per-register pending-write scoreboard, and a sequential flush (clear) engine.
- Sits between decode/issue (scoreboard set, reads) and writeback (writes).

Parameters:
- XLEN, 32, data width of each register.
- DEPTH, 32, number of registers; power of two, >=2. AW = clog2(DEPTH).
- NRD, 2, number of independent read ports.
- ZERO_REG, 0, 1 = register 0 reads 0, ignores writes, never busy.
- BYPASS, 1, 1 = same-cycle writeback data forwarded to reads.

Ports:
- CLK  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Reg_Wr  in  1  writeback enable.
- Rd_Wr  in  AW  writeback address.
- Rd_In  in  XLEN  writeback data.
- Rs_rd  in  NRD*AW  read addresses; port k at [k*AW +: AW].
- Rs_Out  out  NRD*XLEN  read data; port k at [k*XLEN +: XLEN].
- Rs_Busy  out  NRD  port k's register has a pending write.
- Sb_Set  in  1  issue marks a register pending.
- Sb_Addr  in  AW  register to mark pending.
- Clr_Req  in  1  start flush of the whole file.
- Clr_Busy  out  1  flush in progress.

Behaviour:
- Reset, asynchronous, any state, including mid-flush:
  - all registers and all scoreboard bits cleared to 0;
  - FSM to IDLE, flush counter to 0;
  - Clr_Busy=0. Rs_Out reads 0 and Rs_Busy=0 while reset is held.
- Write legality: "write legal" = Reg_Wr && state==IDLE && !(ZERO_REG && Rd_Wr==0).
- Write: when legal, reg[Rd_Wr] <= Rd_In at posedge; 1-cycle latency to array.
- Read, combinational, per port k:
  - ZERO_REG && addr==0 -> 0;
  - else if BYPASS && write legal && Rd_Wr==addr -> Rd_In;
  - else reg[addr].
- Multiple read ports may use the same address; each returns identical data.
- Scoreboard, one bit per register:
  - legal write clears sb[Rd_Wr];
  - Sb_Set (IDLE only, and not ZERO_REG addr 0) sets sb[Sb_Addr];
  - same cycle, same address, set and write: set wins, bit=1 (new producer issued).
- Rs_Busy[k] = sb[addr] && !(bypass hit on port k). ZERO_REG addr 0 -> 0.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on Clr_Req; counter=0.
  - CLEAR: each cycle reg[counter] <= 0, sb[counter] <= 0, counter++.
  - After counter==DEPTH-1 is cleared -> IDLE. CLEAR lasts exactly DEPTH cycles.
- Clr_Busy: registered, 1 for exactly the DEPTH cycles in CLEAR.
- During CLEAR:
  - Reg_Wr, Sb_Set and Clr_Req are ignored (dropped, not queued);
  - no bypass; reads return current array contents, so partially cleared values are visible.
- Counter wraps to 0 on exit; no overflow beyond DEPTH-1.
- All writes, sets and clears take effect on the same posedge.

Test Plan:
- Reset, then write reg5=0xDEADBEEF; next cycle read port0=5 and port1=5 -> both 0xDEADBEEF, Rs_Busy=00.
- Bypass: BYPASS=1, Reg_Wr rd=7, data 0x12345678, same-cycle read of 7 -> 0x12345678. Repeat with BYPASS=0 -> old value 0.
- ZERO_REG=1: write reg0=0xFFFFFFFF, Sb_Set addr 0 -> reads 0, Rs_Busy 0. ZERO_REG=0 -> reads 0xFFFFFFFF.
- Scoreboard:
  - Sb_Set addr 3 -> Rs_Busy=1 next cycle;
  - write rd=3 -> Rs_Busy=0 that cycle, via bypass;
  - simultaneous set+write on 3 -> bit stays 1.
- Flush:
  - fill all 32 regs with index+1, pulse Clr_Req -> Clr_Busy high 32 cycles; Reg_Wr mid-flush has no effect; all regs 0 afterwards;
  - assert rst at flush cycle 10 -> Clr_Busy=0 immediately, all regs 0.
- NRD=4, DEPTH=64, XLEN=64: 4 distinct concurrent reads return correct 64-bit values; address 63 write/read ok.

Source files
------------

// File: rtl/regfile_sb_multi.sv
// Parametrised multi-port register file with a write-to-read bypass, a
// pending-write scoreboard and a sequential flush engine. Decode/issue marks
// registers pending and reads operands. Writeback writes results.
module regfile_sb_multi #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                Reg_Wr,
  input  logic [AW-1:0]       Rd_Wr,
  input  logic [XLEN-1:0]     Rd_In,
  input  logic [NRD*AW-1:0]   Rs_rd,
  output logic [NRD*XLEN-1:0] Rs_Out,
  output logic [NRD-1:0]      Rs_Busy,
  input  logic                Sb_Set,
  input  logic [AW-1:0]       Sb_Addr,
  input  logic                Clr_Req,
  output logic                Clr_Busy
);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]  sb_q, sb_d;

  logic              wr_legal;
  logic              set_legal;
  logic              arr_we;
  logic [AW-1:0]     arr_waddr;
  logic [XLEN-1:0]   arr_wdata;

  // Writes and scoreboard sets are only accepted while idle. The reset term
  // keeps a write that arrives during reset from reaching the read bypass.
  assign wr_legal  = Reg_Wr && !rst && (state_q == IDLE) &&
                     !(ZERO_REG && (Rd_Wr == '0));
  assign set_legal = Sb_Set && !rst && (state_q == IDLE) &&
                     !(ZERO_REG && (Sb_Addr == '0));

  // Clr_Busy is a decode of the state flop, so it is glitch-free and
  // falls as soon as asynchronous reset asserts.
  assign Clr_Busy = (state_q == CLEAR);

  // Flush FSM next-state: walk the counter across every register once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (Clr_Req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // DEPTH is a power of two, so the increment wraps to 0 on exit.
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and flush counter registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single array write port shared by the flush engine and writeback.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = Rd_Wr;
    arr_wdata = Rd_In;
    if (state_q == CLEAR) begin
      arr_we    = 1'b1;
      arr_waddr = cnt_q;
      arr_wdata = '0;
    end else if (wr_legal) begin
      arr_we = 1'b1;
    end
  end

  // Register array storage.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (arr_we) begin
      mem_q[arr_waddr] <= arr_wdata;
    end
  end

  // Scoreboard next-state. The set is applied after the writeback clear, so
  // a newly issued producer wins over a same-address completion.
  always_comb begin
    sb_d = sb_q;
    if (state_q == CLEAR) begin
      sb_d[cnt_q] = 1'b0;
    end else begin
      if (wr_legal) begin
        sb_d[Rd_Wr] = 1'b0;
      end
      if (set_legal) begin
        sb_d[Sb_Addr] = 1'b1;
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // Combinational read ports with optional same-cycle writeback forwarding.
  always_comb begin : read_ports
    logic [AW-1:0] addr;
    logic          hit;
    addr    = '0;
    hit     = 1'b0;
    Rs_Out  = '0;
    Rs_Busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      addr = Rs_rd[k*AW +: AW];
      hit  = BYPASS && wr_legal && (Rd_Wr == addr);
      if (!rst && !(ZERO_REG && (addr == '0))) begin
        Rs_Out[k*XLEN +: XLEN] = hit ? Rd_In : mem_q[addr];
        Rs_Busy[k]             = sb_q[addr] && !hit;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb_multi.sv
// Bench for regfile_sb_multi: directed table, flush/reset sequences,
// randomized traffic against a reference model, and a wide 4-port instance.
module tb_regfile_sb_multi;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  // Shared stimulus for instance A (no zero reg, bypass) and B (zero reg, no bypass)
  logic        wr, set, clr;
  logic [4:0]  rd, sa;
  logic [31:0] din;
  logic [9:0]  rs;
  logic [63:0] outA, outB;
  logic [1:0]  bsyA, bsyB;
  logic        cbA, cbB;

  // Wide instance C
  logic         c_wr;
  logic [5:0]   c_rd;
  logic [63:0]  c_din;
  logic [23:0]  c_rs;
  logic [255:0] c_out;
  logic [3:0]   c_bsy;
  logic         c_cb;
  logic         c_set = 1'b0;
  logic [5:0]   c_sa  = 6'd0;
  logic         c_clr = 1'b0;

  regfile_sb_multi #(.XLEN(32), .DEPTH(32), .NRD(2), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_a (
    .CLK(CLK), .rst(rst), .Reg_Wr(wr), .Rd_Wr(rd), .Rd_In(din), .Rs_rd(rs),
    .Rs_Out(outA), .Rs_Busy(bsyA), .Sb_Set(set), .Sb_Addr(sa), .Clr_Req(clr), .Clr_Busy(cbA));

  regfile_sb_multi #(.XLEN(32), .DEPTH(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
    .CLK(CLK), .rst(rst), .Reg_Wr(wr), .Rd_Wr(rd), .Rd_In(din), .Rs_rd(rs),
    .Rs_Out(outB), .Rs_Busy(bsyB), .Sb_Set(set), .Sb_Addr(sa), .Clr_Req(clr), .Clr_Busy(cbB));

  regfile_sb_multi #(.XLEN(64), .DEPTH(64), .NRD(4), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_c (
    .CLK(CLK), .rst(rst), .Reg_Wr(c_wr), .Rd_Wr(c_rd), .Rd_In(c_din), .Rs_rd(c_rs),
    .Rs_Out(c_out), .Rs_Busy(c_bsy), .Sb_Set(c_set), .Sb_Addr(c_sa), .Clr_Req(c_clr), .Clr_Busy(c_cb));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model for A (c=0) and B (c=1) ----------------
  logic [31:0] m_mem [2][32];
  logic        m_sb  [2][32];
  int          m_left;   // flush cycles still to run
  int          m_idx;    // next register the flush zeroes

  function automatic bit zc(int c); return c == 1; endfunction
  function automatic bit bc(int c); return c == 0; endfunction

  function automatic bit m_wl(int c);
    return !rst && wr && (m_left == 0) && !(zc(c) && rd == 5'd0);
  endfunction

  function automatic logic [31:0] m_out(int c, logic [4:0] a);
    if (rst) return '0;
    if (zc(c) && a == 5'd0) return '0;
    if (bc(c) && m_wl(c) && rd == a) return din;
    return m_mem[c][a];
  endfunction

  function automatic logic m_bz(int c, logic [4:0] a);
    if (rst) return 1'b0;
    if (zc(c) && a == 5'd0) return 1'b0;
    if (bc(c) && m_wl(c) && rd == a) return 1'b0;
    return m_sb[c][a];
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 32; i++) begin
        m_mem[c][i] = '0;
        m_sb[c][i]  = 1'b0;
      end
    m_left = 0;
    m_idx  = 0;
  endtask

  task automatic m_tick();
    if (rst) return;
    if (m_left > 0) begin
      for (int c = 0; c < 2; c++) begin
        m_mem[c][m_idx] = '0;
        m_sb[c][m_idx]  = 1'b0;
      end
      m_idx++;
      m_left--;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (m_wl(c)) begin
          m_mem[c][rd] = din;
          m_sb[c][rd]  = 1'b0;
        end
        if (set && !(zc(c) && sa == 5'd0)) m_sb[c][sa] = 1'b1;
      end
      if (clr) begin
        m_left = 32;
        m_idx  = 0;
      end
    end
  endtask

  task automatic m_check();
    logic [4:0]  a;
    logic [31:0] ao;
    logic        ab;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 2; k++) begin
        a  = rs[k*5 +: 5];
        ao = (c == 0) ? outA[k*32 +: 32] : outB[k*32 +: 32];
        ab = (c == 0) ? bsyA[k] : bsyB[k];
        chk($sformatf("model out c%0d p%0d a%0d", c, k, a), 64'(ao), 64'(m_out(c, a)));
        chk($sformatf("model busy c%0d p%0d a%0d", c, k, a), 64'(ab), 64'(m_bz(c, a)));
      end
      chk($sformatf("model clr_busy c%0d", c), 64'((c == 0) ? cbA : cbB), 64'(m_left > 0));
    end
  endtask

  task automatic clear_in();
    wr = 1'b0; rd = '0; din = '0; rs = '0; set = 1'b0; sa = '0; clr = 1'b0;
  endtask

  // One clock: inputs already driven; check mid-cycle, advance model at the edge.
  task automatic cycle(input bit use_model);
    @(negedge CLK);
    if (use_model) m_check();
    @(posedge CLK);
    m_tick();
    #1;
  endtask

  task automatic fill_regs();
    for (int i = 0; i < 32; i++) begin
      wr = 1'b1; rd = 5'(i); din = 32'(i + 1); rs = {5'(i), 5'(i)};
      cycle(1);
    end
    clear_in();
  endtask

  task automatic all_zero(input string tag);
    for (int i = 0; i < 32; i += 2) begin
      rs = {5'(i + 1), 5'(i)};
      @(negedge CLK);
      chk($sformatf("%s A r%0d/%0d", tag, i, i + 1), outA, 64'd0);
      chk($sformatf("%s B r%0d/%0d", tag, i, i + 1), outB, 64'd0);
      @(posedge CLK);
      m_tick();
      #1;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          wr;
    logic [4:0]  rd;
    logic [31:0] din;
    bit          set;
    logic [4:0]  sa;
    logic [4:0]  r0, r1;
    logic [31:0] a0, a1;
    logic [1:0]  ab;
    logic [31:0] b0, b1;
    logic [1:0]  bb;
  } vec_t;
  vec_t tv [11];

  task automatic tv_set(input int i, input int w, input int r, input logic [31:0] d,
                        input int s, input int sad, input int p0, input int p1,
                        input logic [31:0] a0, input logic [31:0] a1, input int ab,
                        input logic [31:0] b0, input logic [31:0] b1, input int bb);
    tv[i].wr = w[0]; tv[i].rd = 5'(r); tv[i].din = d; tv[i].set = s[0]; tv[i].sa = 5'(sad);
    tv[i].r0 = 5'(p0); tv[i].r1 = 5'(p1);
    tv[i].a0 = a0; tv[i].a1 = a1; tv[i].ab = 2'(ab);
    tv[i].b0 = b0; tv[i].b1 = b1; tv[i].bb = 2'(bb);
  endtask

  // ---------------- wide instance shadow ----------------
  logic [63:0] c_mem [64];

  function automatic logic [63:0] c_exp(logic [5:0] a);
    if (c_wr && c_rd == a) return c_din;
    return c_mem[a];
  endfunction

  task automatic c_cycle(input string tag);
    logic [5:0] a;
    @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      a = c_rs[k*6 +: 6];
      chk($sformatf("%s C p%0d a%0d", tag, k, a), c_out[k*64 +: 64], c_exp(a));
    end
    chk($sformatf("%s C busy", tag), 64'(c_bsy), 64'd0);
    chk($sformatf("%s C clr_busy", tag), 64'(c_cb), 64'd0);
    @(posedge CLK);
    if (c_wr) c_mem[c_rd] = c_din;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_in();
    c_wr = 1'b0; c_rd = '0; c_din = '0; c_rs = '0;
    for (int i = 0; i < 64; i++) c_mem[i] = '0;
    m_reset();

    // Reset held: outputs forced quiet even with a write/set being driven.
    wr = 1'b1; rd = 5'd4; din = 32'hAAAA_5555; rs = {5'd4, 5'd4}; set = 1'b1; sa = 5'd4;
    c_wr = 1'b1; c_rd = 6'd4; c_din = 64'h1111; c_rs = {6'd4, 6'd4, 6'd4, 6'd4};
    @(negedge CLK);
    chk("reset outA", outA, 64'd0);
    chk("reset outB", outB, 64'd0);
    chk("reset busyA", 64'(bsyA), 64'd0);
    chk("reset busyB", 64'(bsyB), 64'd0);
    chk("reset clrbusyA", 64'(cbA), 64'd0);
    chk("reset clrbusyB", 64'(cbB), 64'd0);
    chk("reset outC lo", c_out[63:0], 64'd0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    rst = 1'b0;
    clear_in();
    c_wr = 1'b0; c_rd = '0; c_din = '0; c_rs = '0;

    // Directed table: expectations worked out by hand for A and B.
    tv_set(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0);
    tv_set(1, 0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    tv_set(2, 1, 7, 32'h12345678, 0, 0, 7, 5, 32'h12345678, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0);
    tv_set(3, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 7, 32'hFFFFFFFF, 32'h12345678, 0, 0, 32'h12345678, 0);
    tv_set(4, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 0, 0, 0);
    tv_set(5, 0, 0, 0, 1, 3, 3, 0, 0, 32'hFFFFFFFF, 2, 0, 0, 0);
    tv_set(6, 1, 3, 32'h33, 0, 0, 3, 3, 32'h33, 32'h33, 0, 0, 0, 3);
    tv_set(7, 0, 0, 0, 0, 0, 3, 3, 32'h33, 32'h33, 0, 32'h33, 32'h33, 0);
    tv_set(8, 1, 3, 32'h44, 1, 3, 3, 5, 32'h44, 32'hDEADBEEF, 0, 32'h33, 32'hDEADBEEF, 0);
    tv_set(9, 0, 0, 0, 0, 0, 3, 0, 32'h44, 32'hFFFFFFFF, 3, 32'h44, 0, 1);
    tv_set(10, 1, 0, 0, 0, 0, 0, 3, 0, 32'h44, 2, 0, 32'h44, 2);

    for (int i = 0; i < 11; i++) begin
      wr = tv[i].wr; rd = tv[i].rd; din = tv[i].din; set = tv[i].set; sa = tv[i].sa;
      clr = 1'b0; rs = {tv[i].r1, tv[i].r0};
      @(negedge CLK);
      chk($sformatf("tv%0d A out", i), outA, {tv[i].a1, tv[i].a0});
      chk($sformatf("tv%0d A busy", i), 64'(bsyA), 64'(tv[i].ab));
      chk($sformatf("tv%0d B out", i), outB, {tv[i].b1, tv[i].b0});
      chk($sformatf("tv%0d B busy", i), 64'(bsyB), 64'(tv[i].bb));
      chk($sformatf("tv%0d A clr_busy", i), 64'(cbA), 64'd0);
      @(posedge CLK);
      m_tick();
      #1;
    end
    clear_in();

    // Flush: fill, request, check 32 busy cycles with dropped traffic mid-way.
    fill_regs();
    clr = 1'b1; rs = {5'd31, 5'd1};
    cycle(1);
    for (int cyc = 0; cyc < 32; cyc++) begin
      if (cyc == 5) begin
        wr = 1'b1; rd = 5'd31; din = 32'h0BAD; set = 1'b1; sa = 5'd31; clr = 1'b1;
      end else begin
        wr = 1'b0; set = 1'b0; clr = 1'b0;
      end
      rs = {5'd31, 5'(cyc)};
      @(negedge CLK);
      m_check();
      chk($sformatf("flush clr_busy A cyc%0d", cyc), 64'(cbA), 64'd1);
      @(posedge CLK);
      m_tick();
      #1;
    end
    clear_in();
    @(negedge CLK);
    chk("flush done clr_busy A", 64'(cbA), 64'd0);
    chk("flush done clr_busy B", 64'(cbB), 64'd0);
    @(posedge CLK); m_tick(); #1;
    all_zero("after flush");

    // Reset asserted at flush cycle 10.
    fill_regs();
    clr = 1'b1;
    cycle(1);
    clr = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) cycle(1);
    wr = 1'b1; rd = 5'd20; din = 32'h5; rs = {5'd20, 5'd25};
    #2;
    rst = 1'b1;
    #1;
    chk("mid-flush reset clr_busy A", 64'(cbA), 64'd0);
    chk("mid-flush reset clr_busy B", 64'(cbB), 64'd0);
    chk("mid-flush reset outA", outA, 64'd0);
    chk("mid-flush reset busyA", 64'(bsyA), 64'd0);
    m_reset();
    @(posedge CLK); #1;
    rst = 1'b0;
    clear_in();
    @(negedge CLK);
    chk("post reset clr_busy A", 64'(cbA), 64'd0);
    @(posedge CLK); m_tick(); #1;
    all_zero("after reset");

    // Randomized traffic on A and B against the model.
    for (int n = 0; n < 600; n++) begin
      wr  = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) rd = 5'd0;
      din = $urandom;
      set = ($urandom_range(0, 3) == 0);
      sa  = ($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 31));
      clr = ($urandom_range(0, 79) == 0);
      for (int k = 0; k < 2; k++)
        rs[k*5 +: 5] = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      cycle(1);
    end
    clear_in();

    // Wide instance: distinct concurrent reads including address 63.
    c_wr = 1'b1; c_rd = 6'd1;  c_din = 64'h0123_4567_89AB_CDEF; c_rs = {6'd0, 6'd0, 6'd0, 6'd1};
    c_cycle("wide wr1");
    c_rd = 6'd2;  c_din = 64'hFEDC_BA98_7654_3210; c_rs = {6'd0, 6'd0, 6'd2, 6'd1};
    c_cycle("wide wr2");
    c_rd = 6'd62; c_din = 64'h8000_0000_0000_0001; c_rs = {6'd0, 6'd62, 6'd2, 6'd1};
    c_cycle("wide wr62");
    c_rd = 6'd63; c_din = 64'hFFFF_0000_FFFF_0001; c_rs = {6'd63, 6'd62, 6'd2, 6'd1};
    c_cycle("wide wr63");
    c_wr = 1'b0; c_rs = {6'd1, 6'd2, 6'd62, 6'd63};
    @(negedge CLK);
    chk("wide p0 r63", c_out[63:0],    64'hFFFF_0000_FFFF_0001);
    chk("wide p1 r62", c_out[127:64],  64'h8000_0000_0000_0001);
    chk("wide p2 r2",  c_out[191:128], 64'hFEDC_BA98_7654_3210);
    chk("wide p3 r1",  c_out[255:192], 64'h0123_4567_89AB_CDEF);
    @(posedge CLK); #1;
    for (int n = 0; n < 150; n++) begin
      c_wr  = 1'($urandom_range(0, 1));
      c_rd  = 6'($urandom_range(0, 63));
      c_din = {$urandom, $urandom};
      for (int k = 0; k < 4; k++)
        c_rs[k*6 +: 6] = ($urandom_range(0, 3) == 0) ? c_rd : 6'($urandom_range(0, 63));
      c_cycle("wide rand");
    end
    c_wr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
